// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM + MEM/WB pipeline registers with data-memory handshake and forwarding taps.
// Latency: 2 cycles EX -> write-back outputs, plus one cycle per memory wait cycle.
// Backpressure: pipe_stall holds EX and earlier while a memory access waits; optional DMEM_TIMEOUT_EN abandons it.
module ex_mem_wb_pipe #(
    parameter int DATA_W = 16,
    parameter int RA_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_flush,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_halt,
    output logic              pipe_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              exmem_reg_write,
    output logic              exmem_is_load,
    output logic [RA_W-1:0]   exmem_rd,
    output logic [DATA_W-1:0] exmem_fwd_data,
    output logic              memwb_reg_write,
    output logic [RA_W-1:0]   memwb_rd,
    output logic [DATA_W-1:0] memwb_wdata,
    output logic              wb_halt,
    output logic              dmem_error
);

    typedef struct packed {
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] storeData;
        logic [RA_W-1:0]   rd;
        logic              regWrite;
        logic              memRead;
        logic              memWrite;
        logic              memToReg;
        logic              halt;
    } exmem_t;

    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [RA_W-1:0]   rd;
        logic              regWrite;
        logic              halt;
    } memwb_t;

    exmem_t exmemPay;
    logic   exmemValid;
    memwb_t memwbPay;
    logic   memwbValid;

    logic memOp;
    logic stallNow;
    logic abandon;

    // A live memory instruction in EX/MEM drives the data-memory port until it completes.
    assign memOp    = exmemValid & (exmemPay.memRead | exmemPay.memWrite);
    assign stallNow = memOp & ~dmem_ready;

`ifdef DMEM_TIMEOUT_EN
    logic [3:0] waitCnt;
    logic       errSticky;

    // The 15th consecutive stall cycle gives up on the access.
    assign abandon    = stallNow & (waitCnt == 4'd14);
    assign dmem_error = errSticky;

    // Count stall cycles of the current access; clear whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt   <= 4'd0;
            errSticky <= 1'b0;
        end else begin
            if (!stallNow || abandon) begin
                waitCnt <= 4'd0;
            end else begin
                waitCnt <= waitCnt + 4'd1;
            end
            if (abandon) begin
                errSticky <= 1'b1;
            end
        end
    end
`else
    assign abandon    = 1'b0;
    assign dmem_error = 1'b0;
`endif

    assign pipe_stall = stallNow;

    assign dmem_req   = memOp;
    assign dmem_we    = exmemValid & exmemPay.memWrite;
    assign dmem_addr  = exmemPay.aluResult;
    assign dmem_wdata = exmemPay.storeData;

    // Forwarding taps are qualified by the stage valid so dead instructions never match.
    assign exmem_reg_write = exmemValid & exmemPay.regWrite;
    assign exmem_is_load   = exmemValid & exmemPay.memRead;
    assign exmem_rd        = exmemPay.rd;
    assign exmem_fwd_data  = exmemPay.aluResult;

    assign memwb_reg_write = memwbValid & memwbPay.regWrite;
    assign memwb_rd        = memwbPay.rd;
    assign memwb_wdata     = memwbPay.wdata;
    assign wb_halt         = memwbValid & memwbPay.halt;

    // EX/MEM captures the EX instruction unless the memory stage is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            exmemValid <= 1'b0;
            exmemPay   <= '0;
        end else if (abandon) begin
            exmemValid <= 1'b0;
        end else if (!stallNow) begin
            exmemValid         <= ex_valid & ~ex_flush;
            exmemPay.aluResult <= ex_alu_result;
            exmemPay.storeData <= ex_store_data;
            exmemPay.rd        <= ex_rd;
            exmemPay.regWrite  <= ex_reg_write;
            exmemPay.memRead   <= ex_mem_read;
            exmemPay.memWrite  <= ex_mem_write;
            exmemPay.memToReg  <= ex_mem_to_reg;
            exmemPay.halt      <= ex_halt;
        end
    end

    // MEM/WB takes a bubble on every wait cycle, otherwise the selected write-back data.
    always_ff @(posedge clk) begin
        if (reset) begin
            memwbValid <= 1'b0;
            memwbPay   <= '0;
        end else if (stallNow) begin
            memwbValid <= 1'b0;
        end else begin
            memwbValid        <= exmemValid;
            memwbPay.wdata    <= exmemPay.memToReg ? dmem_rdata : exmemPay.aluResult;
            memwbPay.rd       <= exmemPay.rd;
            memwbPay.regWrite <= exmemPay.regWrite;
            memwbPay.halt     <= exmemPay.halt;
        end
    end

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
module tb_ex_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0, ex_flush = 1'b0;
    logic [15:0] ex_alu_result = '0, ex_store_data = '0;
    logic [1:0]  ex_rd = '0;
    logic        ex_reg_write = 0, ex_mem_read = 0, ex_mem_write = 0, ex_mem_to_reg = 0, ex_halt = 0;
    logic        pipe_stall, dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic [15:0] rdVal = 16'hBEEF;
    logic        dmem_ready;
    logic        exmem_reg_write, exmem_is_load;
    logic [1:0]  exmem_rd;
    logic [15:0] exmem_fwd_data;
    logic        memwb_reg_write;
    logic [1:0]  memwb_rd;
    logic [15:0] memwb_wdata;
    logic        wb_halt, dmem_error;

    // memory model controls
    int   memWait = 0;
    int   memCnt = 0;
    logic modelReady = 1'b0;
    logic memManual = 1'b0;
    logic manualReady = 1'b0;
    assign dmem_ready = memManual ? manualReady : modelReady;

    int cmpCount = 0;
    int errCount = 0;
    int reqCycles = 0, stallCycles = 0, weCycles = 0;

    // expected write-back: {regWrite, rd, wdata, halt}; expected access: {we, addr, wdata}
    logic [19:0] wbQ[$];
    logic [32:0] accQ[$];

    ex_mem_wb_pipe dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_halt(ex_halt),
        .pipe_stall(pipe_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(rdVal), .dmem_ready(dmem_ready),
        .exmem_reg_write(exmem_reg_write), .exmem_is_load(exmem_is_load),
        .exmem_rd(exmem_rd), .exmem_fwd_data(exmem_fwd_data),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
        .wb_halt(wb_halt), .dmem_error(dmem_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmpCount++;
        if (act !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder: ready after memWait cycles of request, restarted per access.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!dmem_req) begin
                modelReady = 1'b0;
                memCnt = 0;
            end else begin
                if (modelReady) memCnt = 0;
                modelReady = (memCnt >= memWait);
                memCnt++;
            end
        end
    end

    // Monitor: pops scoreboards when the DUT presents write-backs or completes accesses.
    initial begin
        forever begin
            @(negedge clk);
            if (dmem_req) reqCycles++;
            if (pipe_stall) stallCycles++;
            if (dmem_req && dmem_we) weCycles++;
            if (memwb_reg_write || wb_halt) begin
                if (wbQ.size() == 0) begin
                    chk("unexpected_wb", {memwb_reg_write, memwb_rd, memwb_wdata, wb_halt}, 64'h0);
                end else begin
                    chk("wb", {memwb_reg_write, memwb_rd, memwb_wdata, wb_halt}, wbQ.pop_front());
                end
            end
            if (dmem_req && dmem_ready) begin
                if (accQ.size() == 0) begin
                    chk("unexpected_access", {dmem_we, dmem_addr, dmem_wdata}, 64'h0);
                end else begin
                    chk("access", {dmem_we, dmem_addr, dmem_wdata}, accQ.pop_front());
                end
            end
        end
    end

    // Present one instruction in EX and hold it until the block accepts it.
    task automatic issue(input logic fl, input logic [15:0] alu, input logic [15:0] sd,
                         input logic [1:0] rd, input logic rw, input logic mr, input logic mw,
                         input logic m2r, input logic hl, input logic expectIt);
        logic st;
        int   n;
        ex_valid = 1'b1; ex_flush = fl; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r; ex_halt = hl;
        n = 0;
        do begin
            @(negedge clk);
            st = pipe_stall;
            @(posedge clk);
            #1;
            n++;
        end while (st && n < 100);
        if (n >= 100) chk("issue_timeout", 64'd1, 64'd0);
        ex_valid = 1'b0; ex_flush = 1'b0;
        if (expectIt && !fl) begin
            if (rw || hl) wbQ.push_back({rw, rd, (m2r ? rdVal : alu), hl});
            if (mr || mw) accQ.push_back({mw, alu, sd});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clrCounts();
        reqCycles = 0; stallCycles = 0; weCycles = 0;
    endtask

    initial begin
        logic seenRelease;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset then idle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_idle", {pipe_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, exmem_reg_write,
                               exmem_is_load, exmem_rd, exmem_fwd_data, memwb_reg_write, memwb_rd,
                               memwb_wdata, wb_halt, dmem_error}, 64'h0);
        end
        @(posedge clk);
        #1;

        // ADD rd=2 -> 0x1234, forwarding taps one and two cycles later
        issue(0, 16'h1234, 16'h0, 2'd2, 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("add_exmem", {exmem_reg_write, exmem_is_load, exmem_rd, exmem_fwd_data}, {1'b1, 1'b0, 2'd2, 16'h1234});
        @(negedge clk);
        chk("add_memwb", {memwb_reg_write, memwb_rd, memwb_wdata}, {1'b1, 2'd1 + 2'd1, 16'h1234});
        idle(2);

        // LW rd=1 addr 0x0040, ready on the third request cycle
        memWait = 2; rdVal = 16'hBEEF; clrCounts();
        issue(0, 16'h0040, 16'h0, 2'd1, 1, 1, 0, 1, 0, 1);
        @(negedge clk);
        chk("lw_is_load", exmem_is_load, 1'b1);
        idle(6);
        chk("lw_req_cycles", reqCycles, 3);
        chk("lw_stall_cycles", stallCycles, 2);

        // SW zero-wait, then a flushed ALU op
        memWait = 0; clrCounts();
        issue(0, 16'h0010, 16'h00AA, 2'd3, 0, 0, 1, 0, 0, 1);
        issue(1, 16'h5555, 16'h0, 2'd3, 1, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("flush_exmem_rw", exmem_reg_write, 1'b0);
        idle(4);
        chk("sw_we_pulses", weCycles, 1);
        chk("sw_stall_cycles", stallCycles, 0);

        // back-to-back zero-wait memory ops, load with reg_write=0, then halt
        rdVal = 16'h0F0F;
        issue(0, 16'h0020, 16'h0, 2'd2, 1, 1, 0, 1, 0, 1);
        issue(0, 16'h0022, 16'hC0DE, 2'd0, 0, 0, 1, 0, 0, 1);
        issue(0, 16'h0024, 16'h0, 2'd1, 0, 1, 0, 1, 0, 1);
        issue(0, 16'h0077, 16'h0, 2'd0, 0, 0, 0, 0, 1, 1);
        idle(5);

        // long wait without timeout exceeding the timeout threshold is only legal when disabled
`ifndef DMEM_TIMEOUT_EN
        memWait = 16; rdVal = 16'hA5A5; clrCounts();
        issue(0, 16'h0030, 16'h0, 2'd3, 1, 1, 0, 1, 0, 1);
        idle(20);
        chk("long_stall_cycles", stallCycles, 16);
        chk("long_no_error", dmem_error, 1'b0);
`endif

        // reset during the second wait cycle of a load
        memManual = 1'b1; manualReady = 1'b0;
        issue(0, 16'h0050, 16'h0, 2'd3, 1, 1, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", {dmem_req, pipe_stall, exmem_reg_write, exmem_is_load, memwb_reg_write}, 64'h0);
        @(posedge clk);
        #1;
        manualReady = 1'b1;
        idle(3);
        manualReady = 1'b0;
        chk("rst_late_ready_req", dmem_req, 1'b0);

`ifdef DMEM_TIMEOUT_EN
        // abandoned access after 15 stall cycles
        clrCounts();
        issue(0, 16'h0060, 16'h0, 2'd2, 1, 1, 0, 1, 0, 0);
        seenRelease = 1'b0;
        for (int i = 0; i < 40 && !seenRelease; i++) begin
            @(negedge clk);
            if (!pipe_stall) seenRelease = 1'b1;
        end
        chk("to_released", seenRelease, 1'b1);
        chk("to_stall_cycles", stallCycles, 15);
        chk("to_after", {dmem_req, pipe_stall, dmem_error}, {1'b0, 1'b0, 1'b1});
        idle(4);
        chk("to_sticky", dmem_error, 1'b1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        chk("to_reset_clears", dmem_error, 1'b0);
        @(posedge clk);
        #1;
`else
        seenRelease = 1'b1;
        chk("no_timeout_error", dmem_error, 1'b0);
`endif
        memManual = 1'b0;

        idle(4);
        chk("wbq_drained", wbQ.size(), 0);
        chk("accq_drained", accQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule

// File: doc/ex_mem_wb_pipe.md
# ex_mem_wb_pipe

Pipeline-register pair (EX/MEM and MEM/WB) of the 16-bit, four-register pipelined CPU, sitting between the ALU stage and register-file write-back. It latches EX results, runs the data-memory access with a ready/request handshake and stall generation, and produces the qualified destination/RegWrite/data signals that the EX-stage forwarding logic consumes. Bubbles and flushes are tracked with per-stage valid bits so that forwarding never matches a dead instruction.

## Interface
- DATA_W, 16, datapath and memory word width
- RA_W, 2, register address width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX stage holds a live instruction
- ex_flush  in  1  kill the EX instruction (branch redirect); has priority over ex_valid
- ex_alu_result  in  DATA_W  ALU result / memory address
- ex_store_data  in  DATA_W  store data (already forwarded)
- ex_rd  in  RA_W  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_halt  in  1 each  control bits
- pipe_stall  out  1  upstream must hold EX and earlier stages this cycle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr, dmem_wdata  out  DATA_W
- dmem_rdata  in  DATA_W  read data, valid when dmem_ready
- dmem_ready  in  1  access completes this cycle
- exmem_reg_write  out  1  valid & reg_write of EX/MEM
- exmem_is_load  out  1  valid & mem_read of EX/MEM
- exmem_rd  out  RA_W; exmem_fwd_data  out  DATA_W (ALU result)
- memwb_reg_write  out  1  valid & reg_write of MEM/WB
- memwb_rd  out  RA_W; memwb_wdata  out  DATA_W (selected write-back data)
- wb_halt  out  1  halt instruction reached write-back
- dmem_error  out  1  sticky access timeout (only with DMEM_TIMEOUT_EN)

## Operation
- EX/MEM load: when !pipe_stall, EX/MEM.valid <= ex_valid & !ex_flush; payload always copied. When pipe_stall, EX/MEM holds.
- Memory op: EX/MEM valid with mem_read or mem_write. dmem_req = that condition; dmem_we = mem_write; dmem_addr = alu_result; dmem_wdata = store_data. All combinational from EX/MEM.
- pipe_stall = memory op pending & !dmem_ready. Non-memory instructions never stall.
- MEM/WB load each cycle: if pipe_stall, MEM/WB.valid <= 0 (bubble); otherwise MEM/WB.valid <= EX/MEM.valid, wdata <= mem_to_reg ? dmem_rdata : alu_result, rd/reg_write/halt copied.
- Stores never write registers; load with reg_write=0 discards data.
- All forwarding outputs gated by stage valid; rd/data outputs show the stored payload regardless.
- wb_halt = MEM/WB.valid & halt; block continues normally afterwards (halt handling is downstream).
- Reset: both valid bits 0, all payload 0, dmem_error 0. Hence every output reads 0 after reset except dmem_addr/dmem_wdata (0 via payload).

## Timing
- Latency EX -> MEM/WB outputs: 2 cycles for non-memory ops and zero-wait memory (dmem_ready same cycle as dmem_req).
- Each wait cycle adds one cycle; exactly one bubble enters MEM/WB per wait cycle.
- dmem_req stays asserted and address/data stable from first request cycle until the dmem_ready cycle inclusive; deasserted the cycle after unless the next instruction is also a memory op (back-to-back requests allowed).
- ex_flush during pipe_stall is ignored by this block (upstream holds the EX instruction; flush takes effect when stall releases, if still asserted).
- Reset mid-access: pending request dropped next cycle; late dmem_ready ignored.

## Configuration
- DMEM_TIMEOUT_EN defined: 4-bit wait counter increments per stall cycle, clears on ready or new access; on reaching 15 stall cycles the access is abandoned — EX/MEM.valid cleared, dmem_req drops, no write-back, dmem_error set (sticky until reset).
- Undefined: no counter, dmem_error tied 0, stall lasts indefinitely until dmem_ready.

## Test plan
- Reset then idle: all outputs 0, pipe_stall 0 for 5 cycles.
- ADD rd=2 result 0x1234, no memory -> cycle+1 exmem_reg_write=1 exmem_rd=2 exmem_fwd_data=0x1234; cycle+2 memwb_reg_write=1 memwb_wdata=0x1234.
- LW rd=1 addr 0x0040, dmem_ready after 3 cycles returning 0xBEEF -> dmem_req high 3 cycles, pipe_stall 2 cycles, 2 bubbles, then memwb_wdata=0xBEEF memwb_rd=1.
- SW addr 0x0010 data 0x00AA zero-wait followed by ex_flush on next instruction -> one dmem_we pulse, no memwb_reg_write for either.
- Reset asserted during 2nd wait cycle of a load -> next cycle dmem_req=0, valid bits 0, later dmem_ready causes no write-back.
- DMEM_TIMEOUT_EN, dmem_ready held 0 -> after 15 stall cycles dmem_req drops, pipe_stall 0, dmem_error=1 and stays 1.
